// File: rtl/lshift_seq_pkg.sv
// Shared shift package: FSM state encoding and default widths for the
// sequential datapath shifters.
package lshift_seq_pkg;

    localparam int unsigned LSHIFT_WIDTH = 16;
    localparam int unsigned LSHIFT_SHW   = 4;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } lshift_state_e;

endpackage

// File: rtl/lshift_seq.sv
// Sequential left shifter: shifts an operand left one bit per cycle,
// inserting a fill bit at the LSB, for a captured shift amount.
//
// Ports:
//   clk    - clock, rising edge
//   rst    - asynchronous active-high reset
//   start  - request a shift; accepted only while ready=1
//   din    - operand, captured at acceptance
//   shamt  - left-shift amount 0..WIDTH-1, captured at acceptance
//   fill   - bit inserted at LSB on each step, captured at acceptance
//   ready  - idle, start will be accepted
//   done   - one-cycle pulse, result valid
//   dout   - shifted result (held until the next accepted start)
//   carry  - last bit shifted out of the MSB
module lshift_seq
    import lshift_seq_pkg::*;
#(
    parameter int unsigned WIDTH = LSHIFT_WIDTH,
    parameter int unsigned SHW   = LSHIFT_SHW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    input  logic [SHW-1:0]   shamt,
    input  logic             fill,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] dout,
    output logic             carry
);

    lshift_state_e    state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             fill_q, fill_d;
    logic             carry_q, carry_d;

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        fill_d  = fill_q;
        carry_d = carry_q;
        ready   = 1'b0;
        done    = 1'b0;

        unique case (state_q)
            StIdle: begin
                ready = 1'b1;
                if (start) begin
                    sreg_d  = din;
                    cnt_d   = shamt;
                    fill_d  = fill;
                    carry_d = 1'b0;
                    state_d = (shamt == '0) ? StDone : StShift;
                end
            end
            StShift: begin
                sreg_d  = {sreg_q[WIDTH-2:0], fill_q};
                carry_d = sreg_q[WIDTH-1];
                cnt_d   = cnt_q - SHW'(1);
                // Counter is nonzero on entry, so it never wraps.
                if (cnt_q == SHW'(1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            sreg_q  <= '0;
            cnt_q   <= '0;
            fill_q  <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
            carry_q <= carry_d;
        end
    end

    assign dout  = sreg_q;
    assign carry = carry_q;

endmodule

// File: tb/tb_lshift_seq.sv
// Directed self-checking bench for lshift_seq.
module tb_lshift_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] din;
    logic [3:0]  shamt;
    logic        fill;
    logic        ready;
    logic        done;
    logic [15:0] dout;
    logic        carry;

    int checks = 0;
    int errors = 0;

    lshift_seq #(
        .WIDTH(16),
        .SHW  (4)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .din  (din),
        .shamt(shamt),
        .fill (fill),
        .ready(ready),
        .done (done),
        .dout (dout),
        .carry(carry)
    );

    always #5 clk = ~clk;

    // Issue one start on the next negedge; report ready seen at that point,
    // cycles from accept to done (-1 if none within budget) and the result.
    task automatic do_op(input logic [15:0] d_in, input logic [3:0] sh, input logic f,
                         output logic rdy, output int lat,
                         output logic [15:0] d_out, output logic c_out);
        @(negedge clk);
        rdy   = ready;
        din   = d_in;
        shamt = sh;
        fill  = f;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        din   = ~d_in;
        shamt = 4'd0;
        fill  = ~f;
        lat   = -1;
        d_out = 'x;
        c_out = 1'bx;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done) begin
                lat   = i;
                d_out = dout;
                c_out = carry;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        din   = 16'h5A5A;
        shamt = 4'd3;
        fill  = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: ready=%b done=%b, required ready=1 done=0", ready, done);
        end
        checks++;
        if (dout !== 16'h0000 || carry !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: dout=%h carry=%b, required 0000/0", dout, carry);
        end
        checks++;
        if (dut.cnt_q !== 4'd0) begin
            errors++;
            $display("FAIL reset_cnt: cnt=%0d, required 0", dut.cnt_q);
        end
        rst = 1'b0;
    endtask

    task automatic test_shift_one();
        logic rdy; int lat; logic [15:0] d; logic c;
        do_op(16'h8001, 4'd1, 1'b0, rdy, lat, d, c);
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL shift1_latency: got %0d, required 2", lat);
        end
        checks++;
        if (d !== 16'h0002 || c !== 1'b1) begin
            errors++;
            $display("FAIL shift1_result: dout=%h carry=%b, required 0002/1", d, c);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || ready !== 1'b1 || dout !== 16'h0002 || carry !== 1'b1) begin
            errors++;
            $display("FAIL shift1_hold: done=%b ready=%b dout=%h carry=%b, required 0/1/0002/1",
                     done, ready, dout, carry);
        end
    endtask

    task automatic test_shamt_zero();
        logic rdy; int lat; logic [15:0] d; logic c;
        do_op(16'h1234, 4'd0, 1'b1, rdy, lat, d, c);
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("FAIL shamt0_latency: got %0d, required 1", lat);
        end
        checks++;
        if (d !== 16'h1234 || c !== 1'b0) begin
            errors++;
            $display("FAIL shamt0_result: dout=%h carry=%b, required 1234/0", d, c);
        end
    endtask

    task automatic test_shamt_max();
        logic rdy; int lat; logic [15:0] d; logic c;
        do_op(16'h0001, 4'd15, 1'b1, rdy, lat, d, c);
        checks++;
        if (lat !== 16) begin
            errors++;
            $display("FAIL shamt15_latency: got %0d, required 16", lat);
        end
        checks++;
        if (d !== 16'hFFFF || c !== 1'b0) begin
            errors++;
            $display("FAIL shamt15_result: dout=%h carry=%b, required FFFF/0", d, c);
        end
        // din[1]=1 case exercises the carry path at maximum shift.
        do_op(16'h0002, 4'd15, 1'b0, rdy, lat, d, c);
        checks++;
        if (d !== 16'h0000 || c !== 1'b1) begin
            errors++;
            $display("FAIL shamt15_carry: dout=%h carry=%b, required 0000/1", d, c);
        end
    endtask

    task automatic test_busy_start();
        int lat; int ndone;
        @(negedge clk);
        din   = 16'h00F0;
        shamt = 4'd4;
        fill  = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        // Second busy cycle: start must be ignored, not queued.
        start = 1'b1;
        din   = 16'hFFFF;
        shamt = 4'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = -1;
        ndone = 0;
        for (int i = 3; i <= 20; i++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (lat == -1) begin
                    lat = i;
                    checks++;
                    if (dout !== 16'h0F00 || carry !== 1'b0) begin
                        errors++;
                        $display("FAIL busy_result: dout=%h carry=%b, required 0F00/0",
                                 dout, carry);
                    end
                end
            end
        end
        checks++;
        if (lat !== 5 || ndone !== 1) begin
            errors++;
            $display("FAIL busy_done: latency=%0d count=%0d, required 5/1", lat, ndone);
        end
    endtask

    task automatic test_reset_abort();
        int ndone; logic rdy; int lat; logic [15:0] d; logic c;
        @(negedge clk);
        din   = 16'hAAAA;
        shamt = 4'd8;
        fill  = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (ready !== 1'b1 || dout !== 16'h0000 || carry !== 1'b0) begin
            errors++;
            $display("FAIL abort_async: ready=%b dout=%h carry=%b, required 1/0000/0",
                     ready, dout, carry);
        end
        ndone = 0;
        @(negedge clk);
        // Release reset together with a start: it must be taken on the next edge.
        rst   = 1'b0;
        din   = 16'h0003;
        shamt = 4'd2;
        fill  = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = -1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (lat == -1) lat = i;
            end
        end
        checks++;
        if (ndone !== 1 || lat !== 3) begin
            errors++;
            $display("FAIL abort_restart: dones=%0d latency=%0d, required 1/3", ndone, lat);
        end
        checks++;
        if (dout !== 16'h000C) begin
            errors++;
            $display("FAIL abort_restart_result: dout=%h, required 000C", dout);
        end
        do_op(16'h0000, 4'd0, 1'b0, rdy, lat, d, c);
    endtask

    task automatic test_back_to_back();
        logic rdy; int lat; logic [15:0] d; logic c;
        do_op(16'h0003, 4'd2, 1'b0, rdy, lat, d, c);
        checks++;
        if (lat !== 3 || d !== 16'h000C || c !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first: latency=%0d dout=%h carry=%b, required 3/000C/0", lat, d, c);
        end
        do_op(16'hC000, 4'd1, 1'b1, rdy, lat, d, c);
        checks++;
        if (rdy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready: ready=%b, required 1", rdy);
        end
        checks++;
        if (lat !== 2 || d !== 16'h8001 || c !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second: latency=%0d dout=%h carry=%b, required 2/8001/1", lat, d, c);
        end
    endtask

    initial begin
        test_reset();
        test_shift_one();
        test_shamt_zero();
        test_shamt_max();
        test_busy_start();
        test_reset_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lshift_seq.md
LSHIFT_SEQ -- requirements
Module: lshift_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the data width.
REQ-002 The block SHALL have parameter SHW, default 4, giving the shift-amount width (clog2 of WIDTH).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: request a shift; accepted only when ready=1.
REQ-006 The block SHALL have port din, input, WIDTH bits: operand captured at acceptance.
REQ-007 The block SHALL have port shamt, input, SHW bits: left-shift amount 0..WIDTH-1, captured at acceptance.
REQ-008 The block SHALL have port fill, input, 1 bit: bit inserted at LSB on every shift step, captured at acceptance.
REQ-009 The block SHALL have port ready, output, 1 bit: block idle, start will be accepted.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse, result valid.
REQ-011 The block SHALL have port dout, output, WIDTH bits: shifted result.
REQ-012 The block SHALL have port carry, output, 1 bit: last bit shifted out of the MSB.

Function
REQ-013 The FSM SHALL have states IDLE, SHIFT and DONE.
REQ-014 ready SHALL be 1 only in IDLE.
REQ-015 In IDLE with start=1, the block SHALL load din into the shift register, shamt into the down-counter and fill into a fill register, and clear carry.
REQ-016 From IDLE with start=1, the next state SHALL be DONE if shamt=0, otherwise SHIFT.
REQ-017 Each SHIFT cycle SHALL perform {reg[WIDTH-2:0], fill_r}.
REQ-018 Each SHIFT cycle SHALL load carry with reg[WIDTH-1].
REQ-019 Each SHIFT cycle SHALL decrement the counter, going to DONE when the counter equals 1 and staying in SHIFT otherwise.
REQ-020 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-021 done SHALL be high in exactly the cycle that is shamt+1 cycles after the start-accept cycle.
REQ-022 A start=1 asserted in SHIFT or DONE SHALL be ignored and SHALL NOT be queued.
REQ-023 dout and carry SHALL hold the last result from DONE until the next accepted start.
REQ-024 dout and carry are undefined-but-stable during SHIFT; the bench SHALL NOT check them there.
REQ-025 With shamt=0, dout SHALL equal din and carry SHALL be 0.
REQ-026 With shamt=WIDTH-1, dout SHALL equal {din[0], {WIDTH-1{fill}}} and carry SHALL equal din[1].
REQ-027 din, shamt and fill changing after acceptance SHALL NOT affect the operation in progress.
REQ-028 The counter SHALL be SHW bits wide and SHALL never wrap; there is no shift of WIDTH or more.

Reset
REQ-029 On rst=1, state SHALL go to IDLE immediately, independent of clk.
REQ-030 On rst=1, ready SHALL be 1 and done SHALL be 0.
REQ-031 On rst=1, dout SHALL be 0, carry SHALL be 0 and the counter SHALL be 0.
REQ-032 Reset asserted mid-SHIFT SHALL abort the operation, and no done pulse SHALL follow.
REQ-033 The first start SHALL be accepted on the first rising edge after rst deasserts.

Structure
REQ-034 The state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and default WIDTH/SHW constants SHALL live in the shared shift package used by the datapath shifters.
REQ-035 The block SHALL be one module with no sub-module; the shift register, counter and FSM SHALL be inline.

Verification
REQ-036 The bench SHALL apply din=16'h8001, shamt=1, fill=0, start for one cycle -> done 2 cycles after start, dout=16'h0002, carry=1.
REQ-037 The bench SHALL apply din=16'h1234, shamt=0 -> done in the cycle after start, dout=16'h1234, carry=0.
REQ-038 The bench SHALL apply din=16'h0001, shamt=15, fill=1 -> done 16 cycles after start, dout=16'hFFFF, carry=0.
REQ-039 The bench SHALL apply din=16'h00F0, shamt=4, fill=0, then start=1 with din=16'hFFFF in the second busy cycle -> single done, dout=16'h0F00, carry=0, no second done.
REQ-040 The bench SHALL apply din=16'hAAAA, shamt=8, then rst=1 mid-SHIFT -> ready=1, dout=0, carry=0 immediately, no done.
REQ-041 The bench SHALL issue back-to-back starts on the first ready cycles, din=16'h0003 shamt=2 then din=16'hC000 shamt=1 fill=1 -> results 16'h000C carry=0, then 16'h8001 carry=1.
